// File: rtl/axi_mem_responder_pkg.sv
// Shared types for the AXI memory responder: response codes, FSM states and AXI field typedefs.
package axi_mem_responder_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_t;

    typedef enum logic [1:0] {
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef logic [1:0] axi_burst_t;
    typedef logic [3:0] axi_len_t;
    typedef logic [2:0] axi_size_t;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int STRB_W   = DATA_W / 8;
    localparam int BYTE_LSB = 2;

    // AXI encodes burst length as beats minus one.
    function automatic logic [4:0] beat_count(input axi_len_t len);
        return {1'b0, len} + 5'd1;
    endfunction

endpackage

// File: rtl/axi_mem_responder_strobe_ram.sv
// Word-addressed RAM with one byte-strobed synchronous write port and one asynchronous read port.
module strobe_ram
    import axi_mem_responder_pkg::*;
#(
    parameter int WORDS = 1024,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    // Contents survive reset by design, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder with independent read and write FSMs over a byte-strobed RAM.
// Optional macro AXI_MEM_SLVERR_EN: out-of-range start addresses answer SLVERR instead of aliasing.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ID_W      = 4
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  axi_len_t          arlen,
    input  axi_size_t         arsize,
    input  axi_burst_t        arburst,
    input  logic              arvalid,
    output logic              arready,

    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,

    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  axi_len_t          awlen,
    input  axi_size_t         awsize,
    input  axi_burst_t        awburst,
    input  logic              awvalid,
    output logic              awready,

    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,

    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    rd_state_t         rd_state, rd_state_nxt;
    logic [IDX_W-1:0]  rd_idx;
    logic [4:0]        rd_cnt;
    logic [ID_W-1:0]   rd_id;
    logic              rd_err;

    wr_state_t         wr_state, wr_state_nxt;
    logic [IDX_W-1:0]  wr_idx;
    logic [ID_W-1:0]   wr_id;
    logic              wr_err;

    logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic              ar_oor, aw_oor;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

`ifdef AXI_MEM_SLVERR_EN
    assign ar_oor = |araddr[ADDR_W-1:BYTE_LSB+IDX_W];
    assign aw_oor = |awaddr[ADDR_W-1:BYTE_LSB+IDX_W];
`else
    assign ar_oor = 1'b0;
    assign aw_oor = 1'b0;
`endif

    // Burst type, beat size, awlen and sub-word address bits do not affect behaviour.
    logic unused_ok;
    assign unused_ok = ^{arsize, arburst, awsize, awburst, awlen,
                         araddr[BYTE_LSB-1:0], awaddr[BYTE_LSB-1:0],
                         araddr[ADDR_W-1:BYTE_LSB+IDX_W], awaddr[ADDR_W-1:BYTE_LSB+IDX_W]};

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_state_nxt;
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_nxt = R_BURST;
            R_BURST: if (r_hs && rd_cnt == 5'd1) rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_idx <= '0;
            rd_cnt <= '0;
            rd_id  <= '0;
            rd_err <= 1'b0;
        end else if (ar_hs) begin
            rd_idx <= araddr[BYTE_LSB +: IDX_W];
            rd_cnt <= beat_count(arlen);
            rd_id  <= arid;
            rd_err <= ar_oor;
        end else if (r_hs) begin
            // Index width equals log2(MEM_WORDS), so the increment wraps the burst around memory.
            rd_idx <= rd_idx + 1'b1;
            rd_cnt <= rd_cnt - 5'd1;
        end
    end

    assign arready = (rd_state == R_IDLE);
    assign rvalid  = (rd_state == R_BURST);
    assign rlast   = rvalid && (rd_cnt == 5'd1);
    assign rid     = rd_id;
    assign rresp   = (rvalid && rd_err) ? RESP_SLVERR : RESP_OKAY;
    assign rdata   = rd_err ? '0 : ram_rdata;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= W_ADDR;
        end else begin
            wr_state <= wr_state_nxt;
        end
    end

    // The burst ends on wlast, whatever awlen announced.
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_ADDR:  if (aw_hs) wr_state_nxt = W_DATA;
            W_DATA:  if (w_hs && wlast) wr_state_nxt = W_RESP;
            W_RESP:  if (b_hs) wr_state_nxt = W_ADDR;
            default: wr_state_nxt = W_ADDR;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_idx <= '0;
            wr_id  <= '0;
            wr_err <= 1'b0;
        end else if (aw_hs) begin
            wr_idx <= awaddr[BYTE_LSB +: IDX_W];
            wr_id  <= awid;
            wr_err <= aw_oor;
        end else if (w_hs) begin
            wr_idx <= wr_idx + 1'b1;
        end
    end

    assign awready = (wr_state == W_ADDR);
    assign wready  = (wr_state == W_DATA);
    assign bvalid  = (wr_state == W_RESP);
    assign bid     = wr_id;
    assign bresp   = (bvalid && wr_err) ? RESP_SLVERR : RESP_OKAY;
    assign ram_we  = w_hs && !wr_err;

    // Asynchronous read: a read beat sees the word before a same-cycle write lands.
    strobe_ram #(
        .WORDS (MEM_WORDS)
    ) u_ram (
        .clk   (aclk),
        .we    (ram_we),
        .waddr (wr_idx),
        .wstrb (wstrb),
        .wdata (wdata),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized + directed bench for axi_mem_responder against a word-array reference memory.
module tb_axi_mem_responder;

    localparam int MEM_WORDS = 1024;
    localparam int ID_W      = 4;
`ifdef AXI_MEM_SLVERR_EN
    localparam bit SLVERR_MODE = 1'b1;
`else
    localparam bit SLVERR_MODE = 1'b0;
`endif

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [ID_W-1:0] arid, rid, awid, bid;
    logic [31:0]     araddr, awaddr, rdata, wdata;
    logic [3:0]      arlen, awlen, wstrb;
    logic [2:0]      arsize, awsize;
    logic [1:0]      arburst, awburst, rresp, bresp;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];

    axi_mem_responder #(.MEM_WORDS(MEM_WORDS), .ID_W(ID_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
        return SLVERR_MODE && (a >= 32'(4 * MEM_WORDS));
    endfunction

    function automatic int word_of(input logic [31:0] a, input int beat);
        return int'(((a >> 2) + 32'(beat)) % 32'(MEM_WORDS));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic axi_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                             input int nbeats, input int bstall);
        int waitc;
        bit oor;
        oor = is_oor(addr);
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = 4'(nbeats - 1); awsize = 3'd2;
        awburst = 2'($urandom_range(0, 3)); awvalid = 1'b1;
        waitc = 0;
        while (awready !== 1'b1 && waitc < 50) begin @(negedge aclk); waitc++; end
        chk("awready", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(negedge aclk);
            end
            wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
            chk("wready", wready, 1);
            @(negedge aclk);
            if (!oor) ref_mem[word_of(addr, i)] = merge(ref_mem[word_of(addr, i)], wbuf[i], sbuf[i]);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid", bvalid, 1);
        chk("bid", bid, id);
        chk("bresp", bresp, oor ? 2'b10 : 2'b00);
        for (int c = 0; c < bstall; c++) begin
            @(negedge aclk);
            chk("bvalid_hold", bvalid, 1);
            chk("awready_in_resp", awready, 0);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("bvalid_done", bvalid, 0);
        chk("awready_after_b", awready, 1);
    endtask

    task automatic axi_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input int nbeats, input int stall_beat, input int stall_cyc);
        int waitc;
        bit oor;
        logic [31:0] exp_d;
        oor = is_oor(addr);
        @(negedge aclk);
        arid = id; araddr = addr; arlen = 4'(nbeats - 1); arsize = 3'd2;
        arburst = 2'($urandom_range(0, 3)); arvalid = 1'b1;
        waitc = 0;
        while (arready !== 1'b1 && waitc < 50) begin @(negedge aclk); waitc++; end
        chk("arready", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            exp_d = oor ? 32'h0 : ref_mem[word_of(addr, i)];
            if (i == stall_beat) begin
                rready = 1'b0;
                for (int c = 0; c < stall_cyc; c++) begin
                    chk("rvalid_hold", rvalid, 1);
                    chk("rdata_hold", rdata, exp_d);
                    chk("rlast_hold", rlast, (i == nbeats - 1));
                    @(negedge aclk);
                end
                rready = 1'b1;
            end
            chk("rvalid", rvalid, 1);
            chk("rdata", rdata, exp_d);
            chk("rlast", rlast, (i == nbeats - 1));
            chk("rresp", rresp, oor ? 2'b10 : 2'b00);
            chk("rid", rid, id);
            @(negedge aclk);
        end
        rready = 1'b0;
        chk("rvalid_done", rvalid, 0);
        chk("arready_after_r", arready, 1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] old_d;
        int n;

        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

        repeat (3) @(negedge aclk);
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        aresetn = 1'b1;

        // Fill the whole memory through the write channel so the model knows every word.
        for (int base = 0; base < MEM_WORDS; base += 16) begin
            for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom(); sbuf[i] = 4'hF; end
            axi_write(4'(base / 16), 32'(base * 4), 16, 0);
        end

        // Single read of a preloaded word.
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        axi_write(4'd1, 32'h10, 1, 0);
        axi_read(4'd5, 32'h10, 1, -1, 0);

        // Four-beat burst write then read.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        axi_write(4'd2, 32'h100, 4, 0);
        axi_read(4'd6, 32'h100, 4, -1, 0);

        // Byte strobes.
        wbuf[0] = 32'h0; sbuf[0] = 4'hF;
        axi_write(4'd3, 32'h0, 1, 0);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        axi_write(4'd3, 32'h0, 1, 0);
        axi_read(4'd7, 32'h0, 1, -1, 0);

        // Backpressure on R and B.
        axi_read(4'd8, 32'h100, 4, 2, 5);
        wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
        axi_write(4'd9, 32'h40, 1, 3);

        // Wrap at top of memory and the out-of-range start address.
        wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        axi_write(4'd10, 32'hFFC, 2, 0);
        axi_read(4'd11, 32'hFFC, 2, -1, 0);
        axi_read(4'd12, 32'h1000, 1, -1, 0);
        wbuf[0] = 32'h0BADF00D; sbuf[0] = 4'hF;
        axi_write(4'd13, 32'h1000, 1, 0);
        axi_read(4'd14, 32'h0, 1, -1, 0);

        // Write beat and read beat on the same word in the same cycle.
        @(negedge aclk);
        araddr = 32'h4B0; arlen = 4'd0; arid = 4'd4; arvalid = 1'b1;
        awaddr = 32'h4B0; awlen = 4'd0; awid = 4'd4; awvalid = 1'b1;
        chk("same_arready", arready, 1);
        chk("same_awready", awready, 1);
        @(negedge aclk);
        arvalid = 1'b0; awvalid = 1'b0;
        old_d = ref_mem[300];
        wdata = ~old_d; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
        chk("same_rdata_old", rdata, old_d);
        chk("same_wready", wready, 1);
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
        ref_mem[300] = ~old_d;
        chk("same_rvalid_done", rvalid, 0);
        chk("same_bvalid", bvalid, 1);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        axi_read(4'd4, 32'h4B0, 1, -1, 0);

        // Reset during beat 2 of a four-beat read.
        @(negedge aclk);
        araddr = 32'h200; arlen = 4'd3; arid = 4'd15; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        chk("rstmid_beat1", rdata, ref_mem[128]);
        @(negedge aclk);
        chk("rstmid_beat2", rdata, ref_mem[129]);
        aresetn = 1'b0;
        #1;
        chk("rstmid_rvalid", rvalid, 0);
        chk("rstmid_arready", arready, 1);
        chk("rstmid_rid", rid, 0);
        rready = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        axi_read(4'd1, 32'h200, 4, -1, 0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(1, 16);
            a = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
            if ($urandom_range(0, 4) == 0) a = $urandom();
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    wbuf[i] = $urandom(); sbuf[i] = 4'($urandom_range(0, 15));
                end
                axi_write(4'($urandom_range(0, 15)), a, n, $urandom_range(0, 2));
            end else begin
                axi_read(4'($urandom_range(0, 15)), a, n, $urandom_range(0, n - 1),
                         $urandom_range(0, 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
